// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite types: response codes, command-master FSM states and the
// command/response records exchanged with the command master.
package axi4_lite_pkg;

   localparam int unsigned CMD_ADDR_W = 4;
   localparam int unsigned CMD_DATA_W = 32;
   localparam int unsigned CMD_STRB_W = CMD_DATA_W / 8;
   localparam int unsigned RSP_LAT_W  = 8;

   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      EXOKAY = 2'b01,
      SLVERR = 2'b10,
      DECERR = 2'b11
   } resp_t;

   typedef enum logic [2:0] {
      StIdle,
      StWrAwW,
      StWrB,
      StRdAr,
      StRdR,
      StRsp
   } mst_state_e;

   typedef struct packed {
      logic                  is_wr;
      logic [CMD_ADDR_W-1:0] addr;
      logic [CMD_DATA_W-1:0] wdata;
      logic [CMD_STRB_W-1:0] wstrb;
   } cmd_t;

   typedef struct packed {
      logic                  is_wr;
      logic [CMD_DATA_W-1:0] rdata;
      resp_t                 resp;
      logic [RSP_LAT_W-1:0]  lat;
   } rsp_t;

endpackage

// File: rtl/aix4_lite_if.sv
// AXI4-Lite bus bundle with master and slave views.
interface aix4_lite_if #(
   parameter int unsigned ADDR_BIT_WIDTH = 4,
   parameter int unsigned DATA_BIT_WIDTH = 32
);

   logic                        awvalid;
   logic                        awready;
   logic [ADDR_BIT_WIDTH-1:0]   awaddr;
   logic [2:0]                  awprot;
   logic                        wvalid;
   logic                        wready;
   logic [DATA_BIT_WIDTH-1:0]   wdata;
   logic [DATA_BIT_WIDTH/8-1:0] wstrb;
   logic                        bvalid;
   logic                        bready;
   logic [1:0]                  bresp;
   logic                        arvalid;
   logic                        arready;
   logic [ADDR_BIT_WIDTH-1:0]   araddr;
   logic [2:0]                  arprot;
   logic                        rvalid;
   logic                        rready;
   logic [DATA_BIT_WIDTH-1:0]   rdata;
   logic [1:0]                  rresp;

   modport mst_port (
      output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
      output arvalid, araddr, arprot, rready,
      input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );

   modport slv_port (
      input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
      input  arvalid, araddr, arprot, rready,
      output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );

endinterface

// File: rtl/axi4_lite_cmd_mst.sv
// Single-outstanding AXI4-Lite master: turns a valid/ready command stream into one
// AXI4-Lite transaction at a time and returns data, response code and latency.
module axi4_lite_cmd_mst
   import axi4_lite_pkg::*;
#(
   parameter int unsigned ADDR_BIT_WIDTH = CMD_ADDR_W,
   parameter int unsigned DATA_BIT_WIDTH = CMD_DATA_W,
   parameter int unsigned LAT_BIT_WIDTH  = RSP_LAT_W
) (
   input  logic                        i_clk,
   input  logic                        i_sync_rst,
   input  logic                        i_cmd_valid,
   output logic                        o_cmd_ready,
   input  logic                        i_cmd_is_wr,
   input  logic [ADDR_BIT_WIDTH-1:0]   i_cmd_addr,
   input  logic [DATA_BIT_WIDTH-1:0]   i_cmd_wdata,
   input  logic [DATA_BIT_WIDTH/8-1:0] i_cmd_wstrb,
   output logic                        o_rsp_valid,
   input  logic                        i_rsp_ready,
   output logic                        o_rsp_is_wr,
   output logic [DATA_BIT_WIDTH-1:0]   o_rsp_rdata,
   output logic [1:0]                  o_rsp_resp,
   output logic [LAT_BIT_WIDTH-1:0]    o_rsp_lat,
   aix4_lite_if.mst_port               if_m_axi4_lite
);

   if ($bits(if_m_axi4_lite.awaddr) != ADDR_BIT_WIDTH) begin : g_addr_w_chk
      $error("axi4_lite_cmd_mst: ADDR_BIT_WIDTH does not match the interface");
   end
   if ($bits(if_m_axi4_lite.wdata) != DATA_BIT_WIDTH) begin : g_data_w_chk
      $error("axi4_lite_cmd_mst: DATA_BIT_WIDTH does not match the interface");
   end
   if (DATA_BIT_WIDTH != 32 && DATA_BIT_WIDTH != 64) begin : g_data_w_legal_chk
      $error("axi4_lite_cmd_mst: DATA_BIT_WIDTH must be 32 or 64");
   end

   mst_state_e                  state_q;
   logic                        cmd_ready_q;
   logic                        rsp_valid_q;
   logic                        rsp_is_wr_q;
   logic [DATA_BIT_WIDTH-1:0]   rsp_rdata_q;
   logic [1:0]                  rsp_resp_q;
   logic [LAT_BIT_WIDTH-1:0]    rsp_lat_q;
   logic [LAT_BIT_WIDTH-1:0]    lat_q;
   logic                        awvalid_q;
   logic                        wvalid_q;
   logic                        bready_q;
   logic                        arvalid_q;
   logic                        rready_q;
   logic [ADDR_BIT_WIDTH-1:0]   addr_q;
   logic [DATA_BIT_WIDTH-1:0]   wdata_q;
   logic [DATA_BIT_WIDTH/8-1:0] wstrb_q;

   function automatic logic [LAT_BIT_WIDTH-1:0] lat_inc(input logic [LAT_BIT_WIDTH-1:0] v);
      return (&v) ? v : v + LAT_BIT_WIDTH'(1);
   endfunction

   always_ff @(posedge i_clk) begin
      if (i_sync_rst) begin
         state_q     <= StIdle;
         cmd_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_is_wr_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_resp_q  <= '0;
         rsp_lat_q   <= '0;
         lat_q       <= '0;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         bready_q    <= 1'b0;
         arvalid_q   <= 1'b0;
         rready_q    <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
      end else begin
         case (state_q)
            StIdle: begin
               if (i_cmd_valid) begin
                  cmd_ready_q <= 1'b0;
                  addr_q      <= i_cmd_addr;
                  wdata_q     <= i_cmd_wdata;
                  wstrb_q     <= i_cmd_wstrb;
                  lat_q       <= '0;
                  if (i_cmd_is_wr) begin
                     state_q   <= StWrAwW;
                     awvalid_q <= 1'b1;
                     wvalid_q  <= 1'b1;
                  end else begin
                     state_q   <= StRdAr;
                     arvalid_q <= 1'b1;
                  end
               end
            end
            StWrAwW: begin
               lat_q <= lat_inc(lat_q);
               // A dropped valid doubles as the "this channel is done" flag.
               if (if_m_axi4_lite.awready) awvalid_q <= 1'b0;
               if (if_m_axi4_lite.wready)  wvalid_q  <= 1'b0;
               if ((!awvalid_q || if_m_axi4_lite.awready) &&
                   (!wvalid_q  || if_m_axi4_lite.wready)) begin
                  state_q  <= StWrB;
                  bready_q <= 1'b1;
               end
            end
            StWrB: begin
               lat_q <= lat_inc(lat_q);
               if (if_m_axi4_lite.bvalid) begin
                  bready_q    <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  rsp_is_wr_q <= 1'b1;
                  rsp_rdata_q <= '0;
                  rsp_resp_q  <= if_m_axi4_lite.bresp;
                  rsp_lat_q   <= lat_inc(lat_q);
                  state_q     <= StRsp;
               end
            end
            StRdAr: begin
               lat_q <= lat_inc(lat_q);
               if (if_m_axi4_lite.arready) begin
                  arvalid_q <= 1'b0;
                  rready_q  <= 1'b1;
                  state_q   <= StRdR;
               end
            end
            StRdR: begin
               lat_q <= lat_inc(lat_q);
               if (if_m_axi4_lite.rvalid) begin
                  rready_q    <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  rsp_is_wr_q <= 1'b0;
                  rsp_rdata_q <= if_m_axi4_lite.rdata;
                  rsp_resp_q  <= if_m_axi4_lite.rresp;
                  rsp_lat_q   <= lat_inc(lat_q);
                  state_q     <= StRsp;
               end
            end
            StRsp: begin
               if (i_rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  cmd_ready_q <= 1'b1;
                  state_q     <= StIdle;
               end
            end
            default: begin
               state_q     <= StIdle;
               cmd_ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign o_cmd_ready = cmd_ready_q;
   assign o_rsp_valid = rsp_valid_q;
   assign o_rsp_is_wr = rsp_is_wr_q;
   assign o_rsp_rdata = rsp_rdata_q;
   assign o_rsp_resp  = rsp_resp_q;
   assign o_rsp_lat   = rsp_lat_q;

   assign if_m_axi4_lite.awvalid = awvalid_q;
   assign if_m_axi4_lite.awaddr  = addr_q;
   assign if_m_axi4_lite.awprot  = 3'b000;
   assign if_m_axi4_lite.wvalid  = wvalid_q;
   assign if_m_axi4_lite.wdata   = wdata_q;
   assign if_m_axi4_lite.wstrb   = wstrb_q;
   assign if_m_axi4_lite.bready  = bready_q;
   assign if_m_axi4_lite.arvalid = arvalid_q;
   assign if_m_axi4_lite.araddr  = addr_q;
   assign if_m_axi4_lite.arprot  = 3'b000;
   assign if_m_axi4_lite.rready  = rready_q;

endmodule

// File: tb/tb_axi4_lite_cmd_mst.sv
// Directed bench for axi4_lite_cmd_mst against a behavioural 4-register slave
// with programmable ready delays and write response code.
module tb_axi4_lite_cmd_mst;
   import axi4_lite_pkg::*;

   localparam int unsigned AW = 4;
   localparam int unsigned DW = 32;
   localparam int unsigned LW = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cmd_valid, cmd_ready, cmd_is_wr;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_wdata;
   logic [DW/8-1:0] cmd_wstrb;
   logic          rsp_valid, rsp_ready, rsp_is_wr;
   logic [DW-1:0] rsp_rdata;
   logic [1:0]    rsp_resp;
   logic [LW-1:0] rsp_lat;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   aix4_lite_if #(.ADDR_BIT_WIDTH(AW), .DATA_BIT_WIDTH(DW)) axi ();

   axi4_lite_cmd_mst #(
      .ADDR_BIT_WIDTH(AW),
      .DATA_BIT_WIDTH(DW),
      .LAT_BIT_WIDTH (LW)
   ) dut (
      .i_clk         (clk),
      .i_sync_rst    (rst),
      .i_cmd_valid   (cmd_valid),
      .o_cmd_ready   (cmd_ready),
      .i_cmd_is_wr   (cmd_is_wr),
      .i_cmd_addr    (cmd_addr),
      .i_cmd_wdata   (cmd_wdata),
      .i_cmd_wstrb   (cmd_wstrb),
      .o_rsp_valid   (rsp_valid),
      .i_rsp_ready   (rsp_ready),
      .o_rsp_is_wr   (rsp_is_wr),
      .o_rsp_rdata   (rsp_rdata),
      .o_rsp_resp    (rsp_resp),
      .o_rsp_lat     (rsp_lat),
      .if_m_axi4_lite(axi)
   );

   // Behavioural slave: readies rise *_dly cycles after valid, B/R one cycle later.
   int unsigned     aw_dly = 1, w_dly = 1, ar_dly = 1;
   logic [1:0]      b_resp_cfg = OKAY;
   int unsigned     aw_cnt, w_cnt, ar_cnt;
   logic            aw_got, w_got;
   logic [AW-1:0]   aw_addr_l;
   logic [DW-1:0]   w_data_l;
   logic [DW/8-1:0] w_strb_l;
   logic [DW-1:0]   regs [4];

   always @(posedge clk) begin
      if (rst) begin
         axi.awready <= 1'b0;
         axi.wready  <= 1'b0;
         axi.bvalid  <= 1'b0;
         axi.bresp   <= 2'b00;
         axi.arready <= 1'b0;
         axi.rvalid  <= 1'b0;
         axi.rdata   <= '0;
         axi.rresp   <= 2'b00;
         aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
         aw_got <= 1'b0; w_got <= 1'b0;
         aw_addr_l <= '0; w_data_l <= '0; w_strb_l <= '0;
         for (int i = 0; i < 4; i++) regs[i] <= '0;
      end else begin
         if (axi.awready) begin
            axi.awready <= 1'b0; aw_cnt <= 0; aw_got <= 1'b1; aw_addr_l <= axi.awaddr;
         end else if (axi.awvalid && !aw_got) begin
            if (aw_cnt + 1 >= aw_dly) axi.awready <= 1'b1;
            else aw_cnt <= aw_cnt + 1;
         end
         if (axi.wready) begin
            axi.wready <= 1'b0; w_cnt <= 0; w_got <= 1'b1;
            w_data_l <= axi.wdata; w_strb_l <= axi.wstrb;
         end else if (axi.wvalid && !w_got) begin
            if (w_cnt + 1 >= w_dly) axi.wready <= 1'b1;
            else w_cnt <= w_cnt + 1;
         end
         if (axi.bvalid && axi.bready) begin
            axi.bvalid <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0;
            for (int b = 0; b < DW / 8; b++)
               if (w_strb_l[b]) regs[aw_addr_l[3:2]][8*b +: 8] <= w_data_l[8*b +: 8];
         end else if (!axi.bvalid && (aw_got || axi.awready) && (w_got || axi.wready)) begin
            axi.bvalid <= 1'b1; axi.bresp <= b_resp_cfg;
         end
         if (axi.arready) begin
            axi.arready <= 1'b0; ar_cnt <= 0;
            axi.rvalid <= 1'b1; axi.rresp <= OKAY; axi.rdata <= regs[axi.araddr[3:2]];
         end else if (axi.arvalid && !axi.rvalid) begin
            if (ar_cnt + 1 >= ar_dly) axi.arready <= 1'b1;
            else ar_cnt <= ar_cnt + 1;
         end
         if (axi.rvalid && axi.rready) axi.rvalid <= 1'b0;
      end
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_cmd(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [DW/8-1:0] s);
      int n = 0;
      cmd_valid = 1'b1; cmd_is_wr = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
      while (!cmd_ready && n < 100) begin step(); n++; end
      check_eq("cmd_ready_wait", cmd_ready, 1'b1);
      step();
      cmd_valid = 1'b0;
   endtask

   task automatic get_rsp(output logic wr, output logic [DW-1:0] d, output logic [1:0] r,
                          output logic [LW-1:0] l);
      int n = 0;
      while (!rsp_valid && n < 1000) begin step(); n++; end
      check_eq("rsp_valid_wait", rsp_valid, 1'b1);
      wr = rsp_is_wr; d = rsp_rdata; r = rsp_resp; l = rsp_lat;
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
   endtask

   logic          r_wr;
   logic [DW-1:0] r_data;
   logic [1:0]    r_resp;
   logic [LW-1:0] r_lat;
   int            hits;

   initial begin
      cmd_valid = 1'b0; cmd_is_wr = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
      rsp_ready = 1'b0;
      repeat (3) step();
      check_eq("rst_cmd_ready", cmd_ready, 1'b1);
      check_eq("rst_rsp_valid", rsp_valid, 1'b0);
      check_eq("rst_valids", {axi.awvalid, axi.wvalid, axi.arvalid}, 3'b000);
      check_eq("rst_readies", {axi.bready, axi.rready}, 2'b00);
      check_eq("rst_awaddr", axi.awaddr, 4'h0);
      check_eq("rst_rsp_data", {rsp_rdata, rsp_resp, rsp_lat}, 42'h0);
      rst = 1'b0;
      step();

      // Full write then read back
      send_cmd(1'b1, 4'h4, 32'hDEADBEEF, 4'hF);
      get_rsp(r_wr, r_data, r_resp, r_lat);
      check_eq("wr_is_wr", r_wr, 1'b1);
      check_eq("wr_resp", r_resp, OKAY);
      check_eq("wr_lat", r_lat, 8'd3);
      check_eq("wr_rdata_zero", r_data, 32'h0);
      send_cmd(1'b0, 4'h4, 32'h0, 4'h0);
      get_rsp(r_wr, r_data, r_resp, r_lat);
      check_eq("rd_is_wr", r_wr, 1'b0);
      check_eq("rd_rdata", r_data, 32'hDEADBEEF);
      check_eq("rd_resp", r_resp, OKAY);
      check_eq("rd_lat", r_lat, 8'd3);

      // Partial strobe write
      send_cmd(1'b1, 4'h8, 32'h11223344, 4'hF);
      get_rsp(r_wr, r_data, r_resp, r_lat);
      send_cmd(1'b1, 4'h8, 32'hAABBCCDD, 4'h3);
      get_rsp(r_wr, r_data, r_resp, r_lat);
      send_cmd(1'b0, 4'h8, 32'h0, 4'h0);
      get_rsp(r_wr, r_data, r_resp, r_lat);
      check_eq("partial_rdata", r_data, 32'h1122CCDD);

      // AW accepted two cycles ahead of W, error response
      aw_dly = 1; w_dly = 3; b_resp_cfg = SLVERR;
      send_cmd(1'b1, 4'hC, 32'h0000_0001, 4'hF);
      check_eq("split_valids_c1", {axi.awvalid, axi.wvalid}, 2'b11);
      step();
      step();
      check_eq("split_valids_c3", {axi.awvalid, axi.wvalid}, 2'b01);
      get_rsp(r_wr, r_data, r_resp, r_lat);
      check_eq("split_resp", r_resp, SLVERR);
      check_eq("split_lat", r_lat, 8'd5);
      hits = 0;
      repeat (4) begin
         if (rsp_valid) hits++;
         step();
      end
      check_eq("split_single_rsp", hits, 0);
      w_dly = 1; b_resp_cfg = OKAY;

      // Back-pressured response with a new command waiting
      send_cmd(1'b1, 4'h0, 32'h12345678, 4'hF);
      for (int n = 0; n < 20 && !rsp_valid; n++) step();
      cmd_valid = 1'b1; cmd_is_wr = 1'b0; cmd_addr = 4'h0;
      for (int i = 0; i < 5; i++) begin
         check_eq("bp_rsp_valid", rsp_valid, 1'b1);
         check_eq("bp_rsp_data", {rsp_is_wr, rsp_rdata, rsp_resp, rsp_lat}, {1'b1, 42'd3});
         check_eq("bp_cmd_ready", cmd_ready, 1'b0);
         check_eq("bp_bus_idle", {axi.awvalid, axi.wvalid, axi.arvalid}, 3'b000);
         step();
      end
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      check_eq("bp_ready_after", {cmd_ready, axi.arvalid}, 2'b10);
      step();
      cmd_valid = 1'b0;
      check_eq("bp_next_accepted", {cmd_ready, axi.arvalid}, 2'b01);
      get_rsp(r_wr, r_data, r_resp, r_lat);
      check_eq("bp_next_rdata", r_data, 32'h12345678);
      check_eq("bp_next_lat", r_lat, 8'd3);

      // Very slow arready saturates the latency counter
      ar_dly = 300;
      send_cmd(1'b0, 4'h4, 32'h0, 4'h0);
      get_rsp(r_wr, r_data, r_resp, r_lat);
      check_eq("sat_lat", r_lat, 8'd255);
      check_eq("sat_rdata", r_data, 32'hDEADBEEF);
      ar_dly = 1;

      // Reset while waiting in the write-response state
      send_cmd(1'b1, 4'h0, 32'hA5A5A5A5, 4'hF);
      step();
      step();
      check_eq("wrb_bready", axi.bready, 1'b1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_eq("mid_rst_valids", {axi.awvalid, axi.wvalid, axi.arvalid}, 3'b000);
      check_eq("mid_rst_readies", {axi.bready, axi.rready}, 2'b00);
      check_eq("mid_rst_rsp_valid", rsp_valid, 1'b0);
      check_eq("mid_rst_cmd_ready", cmd_ready, 1'b1);
      step();
      check_eq("mid_rst_no_rsp", rsp_valid, 1'b0);
      send_cmd(1'b0, 4'h0, 32'h0, 4'h0);
      get_rsp(r_wr, r_data, r_resp, r_lat);
      check_eq("post_rst_rdata", r_data, 32'h0);
      check_eq("post_rst_lat", r_lat, 8'd3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
